fetch_unit: RTL and testbench

//  Instruction fetch stage feeding imem and consuming its word. Holds the PC, drives imem

---
 rtl/tta_pkg.sv | 23 ++
 rtl/fetch_queue.sv | 83 ++++++++
 rtl/fetch_unit.sv | 84 ++++++++
 tb/tb_fetch_unit.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/tta_pkg.sv
// Shared constants and helpers for the fetch front end.
// PC arithmetic wraps at the instruction-memory size.
package tta_pkg;

    localparam int WORD_W = 24;
    localparam int IMEM_SIZE = 128;
    localparam logic [WORD_W-1:0] RESET_PC = 24'h0;
    localparam logic [WORD_W-1:0] HALT_WORD = 24'hFFFFFF;
    localparam logic [WORD_W-1:0] PC_MASK = WORD_W'(IMEM_SIZE - 1);

    function automatic logic [WORD_W-1:0] pc_wrap(
        input logic [WORD_W-1:0] pc
    );
        return pc & PC_MASK;
    endfunction

    function automatic logic [WORD_W-1:0] pc_inc(
        input logic [WORD_W-1:0] pc
    );
        return pc_wrap(pc + WORD_W'(1));
    endfunction

endpackage

// File: rtl/fetch_queue.sv
// Small shift-style FIFO of {pc, word} pairs; slot 0 is the head.
// Head registers keep their last value when the queue empties.
module fetch_queue #(
    parameter int W = 24,
    parameter int DEPTH = 2,
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic          pop,
    input  logic          flush,
    input  logic [W-1:0]  din_pc,
    input  logic [W-1:0]  din_word,
    output logic [CW-1:0] count,
    output logic          head_valid,
    output logic [W-1:0]  head_pc,
    output logic [W-1:0]  head_word
);

    logic [W-1:0]  pc_q [DEPTH];
    logic [W-1:0]  pc_d [DEPTH];
    logic [W-1:0]  wd_q [DEPTH];
    logic [W-1:0]  wd_d [DEPTH];
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic [CW-1:0] wr_idx;
    logic          vld_q;
    logic          vld_d;
    logic          do_pop;

    assign do_pop = pop & (cnt_q != '0);
    assign wr_idx = cnt_q - CW'(do_pop);

    always_comb begin
        pc_d  = pc_q;
        wd_d  = wd_q;
        cnt_d = cnt_q;
        if (flush) begin
            // Entries are left untouched so the head keeps its last value.
            cnt_d = '0;
        end else begin
            if (do_pop && cnt_q > CW'(1)) begin
                for (int i = 0; i < DEPTH - 1; i++) begin
                    pc_d[i] = pc_q[i+1];
                    wd_d[i] = wd_q[i+1];
                end
            end
            if (push) begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (CW'(i) == wr_idx) begin
                        pc_d[i] = din_pc;
                        wd_d[i] = din_word;
                    end
                end
            end
            cnt_d = cnt_q - CW'(do_pop) + CW'(push);
        end
        vld_d = (cnt_d != '0);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                pc_q[i] <= '0;
                wd_q[i] <= '0;
            end
            cnt_q <= '0;
            vld_q <= 1'b0;
        end else begin
            pc_q  <= pc_d;
            wd_q  <= wd_d;
            cnt_q <= cnt_d;
            vld_q <= vld_d;
        end
    end

    assign count      = cnt_q;
    assign head_valid = vld_q;
    assign head_pc    = pc_q[0];
    assign head_word  = wd_q[0];

endmodule

// File: rtl/fetch_unit.sv
// Fetch stage: PC register, imem capture, redirect and halt control.
// Push decisions use only registered state, so ready never reaches the PC.
module fetch_unit
    import tta_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              run,
    output logic [WORD_W-1:0] imem_addr,
    input  logic [WORD_W-1:0] imem_data,
    output logic [WORD_W-1:0] instr,
    output logic [WORD_W-1:0] instr_pc,
    output logic              instr_valid,
    input  logic              instr_ready,
    input  logic              redir_valid,
    input  logic [WORD_W-1:0] redir_addr,
    output logic              halted
);

    localparam int CW = $clog2(DEPTH + 1);

    logic [WORD_W-1:0] pc_q;
    logic [WORD_W-1:0] pc_d;
    logic              halted_q;
    logic              halted_d;
    logic [CW-1:0]     count;
    logic              push;
    logic              pop;
    logic              is_halt;

    assign push = run & ~halted_q & ~redir_valid
                & (count < CW'(DEPTH));
    assign pop = instr_valid & instr_ready;
    assign is_halt = (imem_data == HALT_WORD);

    always_comb begin
        pc_d     = pc_q;
        halted_d = halted_q;
        if (redir_valid) begin
            pc_d     = pc_wrap(redir_addr);
            halted_d = 1'b0;
        end else if (push) begin
            // A captured halt word parks the PC on its own address.
            if (is_halt) begin
                halted_d = 1'b1;
            end else begin
                pc_d = pc_inc(pc_q);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_q     <= RESET_PC;
            halted_q <= 1'b0;
        end else begin
            pc_q     <= pc_d;
            halted_q <= halted_d;
        end
    end

    fetch_queue #(
        .W     (WORD_W),
        .DEPTH (DEPTH)
    ) u_queue (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (push),
        .pop        (pop),
        .flush      (redir_valid),
        .din_pc     (pc_q),
        .din_word   (imem_data),
        .count      (count),
        .head_valid (instr_valid),
        .head_pc    (instr_pc),
        .head_word  (instr)
    );

    assign imem_addr = pc_q;
    assign halted    = halted_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit with a negedge-latching imem model,
// directed vector table, corner sequences and a queue-based reference model.
module tb_fetch_unit;
    import tta_pkg::*;

    localparam int DEPTH = 2;
    localparam int MSK = IMEM_SIZE - 1;
    localparam int AW = $clog2(IMEM_SIZE);

    logic              clk = 1'b0;
    logic              rst_n;
    logic              run;
    logic [WORD_W-1:0] imem_addr;
    logic [WORD_W-1:0] imem_data;
    logic [WORD_W-1:0] instr;
    logic [WORD_W-1:0] instr_pc;
    logic              instr_valid;
    logic              instr_ready;
    logic              redir_valid;
    logic [WORD_W-1:0] redir_addr;
    logic              halted;

    logic [WORD_W-1:0] rom [IMEM_SIZE];

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    always @(negedge clk) imem_data <= rom[imem_addr[AW-1:0]];

    fetch_unit #(.DEPTH(DEPTH)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .run         (run),
        .imem_addr   (imem_addr),
        .imem_data   (imem_data),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .redir_valid (redir_valid),
        .redir_addr  (redir_addr),
        .halted      (halted)
    );

    typedef struct {
        logic [WORD_W-1:0] pc;
        logic [WORD_W-1:0] w;
    } ent_t;

    ent_t              mq [$];
    ent_t              m_last;
    logic [WORD_W-1:0] m_pc;
    bit                m_halt;

    typedef struct {
        bit                rn;
        bit                rv;
        bit                rdy;
        bit                rd;
        logic [WORD_W-1:0] ra;
        bit                ev;
        logic [WORD_W-1:0] ei;
        logic [WORD_W-1:0] ep;
        logic [WORD_W-1:0] ea;
        bit                eh;
    } vec_t;

    vec_t tv [17];

    function automatic vec_t mk(
        bit rn, bit rv, bit rdy, bit rd, logic [WORD_W-1:0] ra,
        bit ev, logic [WORD_W-1:0] ei, logic [WORD_W-1:0] ep,
        logic [WORD_W-1:0] ea, bit eh
    );
        vec_t v;
        v.rn = rn; v.rv = rv; v.rdy = rdy; v.rd = rd; v.ra = ra;
        v.ev = ev; v.ei = ei; v.ep = ep; v.ea = ea; v.eh = eh;
        return v;
    endfunction

    function automatic logic [WORD_W-1:0] R(int a);
        return 24'h100000 | WORD_W'(a);
    endfunction

    task automatic chk(input string nm, input logic [WORD_W-1:0] act,
                       input logic [WORD_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference: a queue of {pc, word}; the ROM word at the current PC is
    // what imem presents at the capturing edge.
    task automatic model_edge();
        int sz;
        bit p;
        logic [WORD_W-1:0] w;
        if (!rst_n) begin
            mq.delete();
            m_pc   = RESET_PC;
            m_halt = 0;
            m_last = '{pc: '0, w: '0};
        end else begin
            sz = mq.size();
            if (sz > 0 && instr_ready) void'(mq.pop_front());
            p = run && !m_halt && !redir_valid && sz < DEPTH;
            if (redir_valid) begin
                mq.delete();
                m_pc   = redir_addr & MSK;
                m_halt = 0;
            end else if (p) begin
                w = rom[m_pc];
                mq.push_back('{pc: m_pc, w: w});
                if (w == HALT_WORD) m_halt = 1;
                else m_pc = (m_pc + 1) & MSK;
            end
            if (mq.size() > 0) m_last = mq[0];
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic model_check();
        chk("valid", 24'(instr_valid), 24'(mq.size() > 0));
        chk("instr", instr, m_last.w);
        chk("instr_pc", instr_pc, m_last.pc);
        chk("imem_addr", imem_addr, m_pc);
        chk("halted", 24'(halted), 24'(m_halt));
    endtask

    task automatic drive(bit rn, bit rv, bit rdy, bit rd,
                         logic [WORD_W-1:0] ra);
        rst_n = rn; run = rv; instr_ready = rdy;
        redir_valid = rd; redir_addr = ra;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        int exp_pcs [4];
        for (int i = 0; i < IMEM_SIZE; i++) rom[i] = R(i);
        tv[0]  = mk(0, 1, 1, 0, 0,     0, 0,       0,     0,     0);
        tv[1]  = mk(1, 1, 1, 0, 0,     1, R(0),    0,     1,     0);
        tv[2]  = mk(1, 1, 1, 0, 0,     1, R(1),    1,     2,     0);
        tv[3]  = mk(1, 1, 1, 0, 0,     1, R(2),    2,     3,     0);
        tv[4]  = mk(1, 1, 1, 0, 0,     1, R(3),    3,     4,     0);
        tv[5]  = mk(0, 1, 1, 0, 0,     0, 0,       0,     0,     0);
        tv[6]  = mk(1, 1, 0, 0, 0,     1, R(0),    0,     1,     0);
        tv[7]  = mk(1, 1, 0, 0, 0,     1, R(0),    0,     2,     0);
        tv[8]  = mk(1, 1, 0, 0, 0,     1, R(0),    0,     2,     0);
        tv[9]  = mk(1, 1, 0, 0, 0,     1, R(0),    0,     2,     0);
        tv[10] = mk(1, 1, 0, 0, 0,     1, R(0),    0,     2,     0);
        tv[11] = mk(1, 1, 1, 0, 0,     1, R(1),    1,     2,     0);
        tv[12] = mk(1, 1, 1, 0, 0,     1, R(2),    2,     3,     0);
        tv[13] = mk(1, 1, 0, 0, 0,     1, R(2),    2,     4,     0);
        tv[14] = mk(1, 1, 0, 1, 'h40,  0, R(2),    2,     'h40,  0);
        tv[15] = mk(1, 1, 0, 0, 0,     1, R('h40), 'h40,  'h41,  0);
        tv[16] = mk(1, 1, 1, 0, 0,     1, R('h41), 'h41,  'h42,  0);

        drive(0, 0, 0, 0, 0);
        step();
        for (int i = 0; i < 17; i++) begin
            drive(tv[i].rn, tv[i].rv, tv[i].rdy, tv[i].rd, tv[i].ra);
            step();
            chk($sformatf("v%0d.valid", i), 24'(instr_valid), 24'(tv[i].ev));
            chk($sformatf("v%0d.instr", i), instr, tv[i].ei);
            chk($sformatf("v%0d.pc", i), instr_pc, tv[i].ep);
            chk($sformatf("v%0d.addr", i), imem_addr, tv[i].ea);
            chk($sformatf("v%0d.halt", i), 24'(halted), 24'(tv[i].eh));
        end

        // Halt word at address 5, then redirect out of it.
        rom[5] = HALT_WORD;
        drive(0, 1, 1, 0, 0);
        step();
        step();
        drive(1, 1, 1, 0, 0);
        for (int i = 0; i < 30; i++) begin
            step();
            model_check();
            if (halted) break;
        end
        chk("halt.flag", 24'(halted), 24'(1));
        chk("halt.word", instr, HALT_WORD);
        chk("halt.pc", instr_pc, 5);
        chk("halt.valid", 24'(instr_valid), 24'(1));
        for (int i = 0; i < 3; i++) begin
            step();
            chk("halt.novalid", 24'(instr_valid), 24'(0));
            chk("halt.addr", imem_addr, 5);
        end
        drive(1, 1, 1, 1, 0);
        step();
        chk("unhalt.flag", 24'(halted), 24'(0));
        chk("unhalt.addr", imem_addr, 0);
        drive(1, 1, 1, 0, 0);
        step();
        chk("unhalt.valid", 24'(instr_valid), 24'(1));
        chk("unhalt.pc", instr_pc, 0);

        // Wrap at the top of imem, then masking of an out-of-range target.
        exp_pcs = '{126, 127, 0, 1};
        drive(1, 1, 1, 1, IMEM_SIZE - 2);
        step();
        drive(1, 1, 1, 0, 0);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("wrap.valid", 24'(instr_valid), 24'(1));
            chk("wrap.pc", instr_pc, WORD_W'(exp_pcs[i]));
            model_check();
        end
        drive(1, 1, 1, 1, 'h85);
        step();
        chk("mask.addr", imem_addr, 5);
        drive(1, 1, 1, 0, 0);

        // Reset while the queue is full.
        drive(1, 1, 0, 1, 'h10);
        step();
        drive(1, 1, 0, 0, 0);
        step();
        step();
        step();
        chk("midrst.pre", 24'(instr_valid), 24'(1));
        drive(0, 1, 0, 0, 0);
        step();
        chk("midrst.valid", 24'(instr_valid), 24'(0));
        chk("midrst.addr", imem_addr, RESET_PC);
        chk("midrst.halt", 24'(halted), 24'(0));
        chk("midrst.instr", instr, 0);

        // Randomized traffic against the reference model.
        for (int i = 0; i < IMEM_SIZE; i++) rom[i] = 24'($urandom);
        rom[5]  = HALT_WORD;
        rom[77] = HALT_WORD;
        step();
        for (int i = 0; i < 3000; i++) begin
            drive($urandom_range(0, 99) != 0,
                  $urandom_range(0, 9) < 8,
                  $urandom_range(0, 9) < 6,
                  $urandom_range(0, 19) == 0,
                  24'($urandom));
            step();
            model_check();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
